// File: rtl/video_in_measure_pack.sv
// Video front-end: registers and expands pixels to 32-bit ARGB, measures frame geometry,
// and holds de low until the geometry has been stable for STABLE_FRAMES frames.
module video_in_measure_pack #(
  parameter string       PIX_FMT       = "RGB888",
  parameter int unsigned IN_DSIZE      = 24,
  parameter logic [7:0]  ALPHA         = 8'hFF,
  parameter string       VS_POL        = "HIGH",
  parameter int unsigned STABLE_FRAMES = 2
) (
  input  logic                pclk,
  input  logic                prst_n,
  input  logic                vsync_in,
  input  logic                de_in,
  input  logic [IN_DSIZE-1:0] data_in,
  output logic                vsync_out,
  output logic                de_out,
  output logic [31:0]         data_out,
  output logic [23:0]         video_width,
  output logic [11:0]         video_height,
  output logic                locked,
  output logic                frame_err
);

  typedef enum logic [1:0] {StUnlock, StCheck, StLock} state_e;

  localparam logic [3:0] StableCnt = 4'(STABLE_FRAMES);

  state_e      state_q, state_d;
  logic        vs, vs_q, de_q;
  logic        frame_end, frame_start, line_end;
  logic [23:0] rgb;
  logic        vsync_out_q, de_out_q, pass_en_q, frame_err_q, frame_err_d;
  logic [31:0] data_out_q;
  logic [23:0] pix_q, pix_d, first_w_q, first_w_d, ref_w_q, ref_w_d, width_q;
  logic [11:0] line_q, line_d, ref_h_q, ref_h_d, height_q;
  logic        line_err_q, line_err_d;
  logic [3:0]  match_cnt_q, match_cnt_d;
  logic        valid, match;

  assign vs          = (VS_POL == "LOW") ? ~vsync_in : vsync_in;
  assign frame_end   = vs & ~vs_q;
  assign frame_start = ~vs & vs_q;
  assign line_end    = de_q & ~de_in;

  if (PIX_FMT == "RGB565") begin : g_rgb565
    // Replicate MSBs into the low bits so full-scale 5/6-bit values map to 8'hFF.
    assign rgb = {data_in[15:11], data_in[15:13], data_in[10:5], data_in[10:9],
                  data_in[4:0], data_in[4:2]};
  end else begin : g_rgb888
    assign rgb = data_in[23:0];
  end

  // Geometry counters.
  always_comb begin
    pix_d      = pix_q;
    line_d     = line_q;
    first_w_d  = first_w_q;
    line_err_d = line_err_q;
    if (vs || line_end) begin
      pix_d = '0;
    end else if (de_in && pix_q != '1) begin
      pix_d = pix_q + 24'd1;
    end
    if (frame_start) begin
      line_d     = '0;
      first_w_d  = '0;
      line_err_d = 1'b0;
    end else begin
      if (line_end) begin
        if (line_q != '1) line_d = line_q + 12'd1;
        if (line_q == '0) first_w_d = pix_q;
        else if (pix_q != first_w_q) line_err_d = 1'b1;
      end
      if (de_in && vs) line_err_d = 1'b1;
    end
  end

  assign valid = !line_err_q && (line_q != '0) && (first_w_q != '0);
  assign match = valid && (first_w_q == ref_w_q) && (line_q == ref_h_q);

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) state_q <= StUnlock;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (frame_end) begin
      unique case (state_q)
        StUnlock: if (valid) state_d = (STABLE_FRAMES == 1) ? StLock : StCheck;
        StCheck: begin
          if (!valid) state_d = StUnlock;
          else if (match && (match_cnt_q + 4'd1 == StableCnt)) state_d = StLock;
        end
        StLock:  if (!match) state_d = StUnlock;
        default: state_d = StUnlock;
      endcase
    end
  end

  always_comb begin
    ref_w_d     = ref_w_q;
    ref_h_d     = ref_h_q;
    match_cnt_d = match_cnt_q;
    frame_err_d = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        StUnlock: begin
          if (valid) begin
            ref_w_d     = first_w_q;
            ref_h_d     = line_q;
            match_cnt_d = 4'd1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        StCheck: begin
          if (match) begin
            match_cnt_d = match_cnt_q + 4'd1;
          end else if (valid) begin
            ref_w_d     = first_w_q;
            ref_h_d     = line_q;
            match_cnt_d = 4'd1;
            frame_err_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        StLock:  frame_err_d = !match;
        default: frame_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge pclk or negedge prst_n) begin
    if (!prst_n) begin
      vs_q        <= 1'b0;
      de_q        <= 1'b0;
      vsync_out_q <= 1'b0;
      de_out_q    <= 1'b0;
      data_out_q  <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      first_w_q   <= '0;
      line_err_q  <= 1'b0;
      ref_w_q     <= '0;
      ref_h_q     <= '0;
      match_cnt_q <= '0;
      frame_err_q <= 1'b0;
      pass_en_q   <= 1'b0;
      width_q     <= '0;
      height_q    <= '0;
    end else begin
      vs_q        <= vs;
      de_q        <= de_in;
      vsync_out_q <= vs;
      de_out_q    <= de_in & pass_en_q;
      data_out_q  <= {ALPHA, rgb};
      pix_q       <= pix_d;
      line_q      <= line_d;
      first_w_q   <= first_w_d;
      line_err_q  <= line_err_d;
      ref_w_q     <= ref_w_d;
      ref_h_q     <= ref_h_d;
      match_cnt_q <= match_cnt_d;
      frame_err_q <= frame_err_d;
      // Gating only changes at a frame boundary so no frame is ever cut short.
      if (frame_start) pass_en_q <= (state_q == StLock);
      if (state_d == StLock && state_q != StLock) begin
        width_q  <= ref_w_d;
        height_q <= ref_h_d;
      end
    end
  end

  assign vsync_out    = vsync_out_q;
  assign de_out       = de_out_q;
  assign data_out     = data_out_q;
  assign video_width  = width_q;
  assign video_height = height_q;
  assign locked       = (state_q == StLock);
  assign frame_err    = frame_err_q;

endmodule

// File: doc/video_in_measure_pack.md
Name: video_in_measure_pack

Overview:
- Front-end conditioner in the pclk domain. It sits directly upstream of the 32-bit video-to-DDR packer.
- Takes raw sensor/decoder video (vsync, de, 24- or 16-bit RGB), expands each pixel to 32-bit ARGB, and measures active width and height per frame.
- Publishes video_width/video_height only after the geometry has been stable for STABLE_FRAMES frames.
- Gates de until lock, so the downstream packer never writes a frame with unknown geometry.

Parameters:
- PIX_FMT, "RGB888", input format: "RGB888" (IN_DSIZE must be 24) or "RGB565" (IN_DSIZE must be 16).
- IN_DSIZE, 24, input pixel bus width.
- ALPHA, 8'hFF, constant placed in data_out[31:24].
- VS_POL, "HIGH", input vsync polarity; "LOW" inverts vsync_in internally. vsync_out is always active-high.
- STABLE_FRAMES, 2, number of consecutive identical valid frames required to lock (1..15).

Ports:
- pclk  in  1  pixel clock
- prst_n  in  1  reset
- vsync_in  in  1  frame sync, polarity per VS_POL
- de_in  in  1  active pixel qualifier
- data_in  in  IN_DSIZE  pixel; RGB888 = {R,G,B}, RGB565 = {R5,G6,B5}
- vsync_out  out  1  active-high vsync, delayed 1 cycle
- de_out  out  1  de_in delayed 1 cycle, AND pass_en
- data_out  out  32  {ALPHA,R8,G8,B8}, delayed 1 cycle
- video_width  out  24  locked active pixels per line
- video_height  out  12  locked active lines per frame
- locked  out  1  geometry stable
- frame_err  out  1  1-cycle pulse when a completed frame is invalid or mismatched

Behaviour:
- Clock and reset: clock pclk; reset prst_n, asynchronous, active-low.
- Reset values: all outputs 0, state UNLOCK, pass_en 0, all counters 0.
- Datapath (1-cycle latency, all registered):
  - vsync_out <= vs (vs = vsync_in, inverted when VS_POL = "LOW").
  - de_out <= de_in & pass_en.
  - data_out <= expanded pixel; register it every cycle regardless of de.
  - RGB565 expansion: R8 = {R5,R5[4:2]}, G8 = {G6,G6[5:4]}, B8 = {B5,B5[4:2]}.
- Edge detect: vs_d and de_d are registered.
  - frame_end = vs & ~vs_d.
  - frame_start = ~vs & vs_d.
  - line_end = de_d & ~de_in.
- Pixel counter (24-bit):
  - Increments on de_in.
  - Saturates at 24'hFFFFFF.
  - Clears the cycle after line_end, and while vs.
- Line counter (12-bit):
  - Increments on line_end; saturates at 12'hFFF.
  - Clears on frame_start.
- Line-width consistency:
  - On the first line_end of a frame, first_w <= pixel count.
  - On any later line_end with count != first_w, set line_err (sticky until frame_start).
  - de asserted while vs is high also sets line_err.
- Frame evaluation, on the frame_end cycle. The frame is valid iff:
  - line_err == 0, and
  - line count != 0, and
  - first_w != 0.
- match = valid && first_w == ref_w && lines == ref_h.
- FSM (transitions only on frame_end):
  - UNLOCK:
    - valid: ref_w/ref_h <= measured, match_cnt <= 1.
    - Then go to LOCK if STABLE_FRAMES == 1, else CHECK.
    - Invalid: stay in UNLOCK and pulse frame_err.
  - CHECK:
    - match: match_cnt++; when match_cnt+1 == STABLE_FRAMES go to LOCK.
    - valid but mismatched: reload ref, match_cnt <= 1, pulse frame_err, stay in CHECK.
    - invalid: go to UNLOCK, pulse frame_err.
  - LOCK:
    - match: stay.
    - otherwise: go to UNLOCK, pulse frame_err.
  - frame_err is registered: it goes high on the cycle after frame_end.
- Lock outputs:
  - On entry to LOCK, video_width <= ref_w and video_height <= ref_h (same cycle locked rises).
  - video_width/video_height hold their last locked values while unlocked. They never change while locked.
- pass_en:
  - Updated only on frame_start: pass_en <= (state == LOCK).
  - A frame that begins unlocked is fully suppressed. A lock loss mid-stream suppresses from the next frame_start; the current frame passes out intact.
- vsync during a line (de high at frame_end): that line is counted as truncated; line_err applies to the next frame only if its width differs.
- A frame with no vs pulse is not evaluated; counters saturate without wrapping.

Test Plan:
- Clean stream, 1920x1080, STABLE_FRAMES=2:
  - frame_err never pulses.
  - locked rises at the end of frame 2 with video_width=1920, video_height=1080.
  - de_out is 0 through frames 1–2 and follows de_in (1-cycle delay) from frame 3.
- Lock, then one frame with width 1280:
  - frame_err pulse and locked falls at that frame's end.
  - de_out is suppressed for the following frame.
  - Relock after 2 further 1920x1080 frames, with video_width=1920 held throughout.
- Frame whose line 5 has 1919 pixels:
  - invalid frame, frame_err pulse, state UNLOCK.
  - Counters show no carryover into the next frame.
- RGB565, data_in=16'hF81F:
  - data_out=32'hFFFF00FF one cycle later.
- VS_POL="LOW" with inverted vsync_in:
  - vsync_out is active-high.
  - Geometry matches the clean-stream case.
- prst_n asserted mid-frame while locked:
  - all outputs go to 0 immediately.
  - After release, 2 full frames are needed to relock; the partial first frame is evaluated invalid only if its line widths disagree.
